// File: rtl/cordic_linear_pkg.sv
// Shared types and defaults for the two-requester cordic_linear arbiter.
package cordic_linear_pkg;

  localparam int unsigned FLOAT_SIZE_DEF = 24;
  localparam int unsigned INT_SIZE_DEF   = 8;
  localparam int unsigned W              = INT_SIZE_DEF + FLOAT_SIZE_DEF;
  localparam int unsigned TIMEOUT_DEF    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module cordic_rr_arb2
  import cordic_linear_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |valid;
    grant       = 1'b0;
    if (&valid) begin
      grant = ~last_grant;
    end else begin
      grant = valid[1];
    end
  end

endmodule

// File: rtl/cordic_linear_arbiter.sv
// Shares one cordic_linear core between two requesters, with a watchdog that aborts hung operations.
module cordic_linear_arbiter
  import cordic_linear_pkg::*;
#(
  parameter int unsigned FLOAT_SIZE = FLOAT_SIZE_DEF,
  parameter int unsigned INT_SIZE   = INT_SIZE_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            r0_valid,
  output logic                            r0_ready,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  r0_x,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  r0_y,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  r0_z,
  input  logic                            r0_mode,
  input  logic                            r1_valid,
  output logic                            r1_ready,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  r1_x,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  r1_y,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  r1_z,
  input  logic                            r1_mode,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_id,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  rsp_x,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  rsp_y,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  rsp_z,
  output logic                            rsp_err,
  output logic                            core_start,
  output logic                            core_rst,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  core_x,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  core_y,
  output logic [INT_SIZE+FLOAT_SIZE-1:0]  core_z,
  output logic                            core_mode,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  core_x_out,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  core_y_out,
  input  logic [INT_SIZE+FLOAT_SIZE-1:0]  core_z_out,
  input  logic                            core_done
);

  localparam int unsigned DATA_W = INT_SIZE + FLOAT_SIZE;
  localparam int unsigned CW     = $clog2(TIMEOUT);

  state_t              state, state_d;
  logic                last_grant, last_grant_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic                core_start_d, core_rst_d, core_mode_d;
  logic [DATA_W-1:0]   core_x_d, core_y_d, core_z_d;
  logic                rsp_valid_d, rsp_id_d, rsp_err_d;
  logic [DATA_W-1:0]   rsp_x_d, rsp_y_d, rsp_z_d;
  logic                grant, grant_valid;

  cordic_rr_arb2 u_arb (
    .valid       ({r1_valid, r0_valid}),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // last_grant doubles as the id of the transaction in flight
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    core_start_d = 1'b0;
    core_rst_d   = 1'b0;
    core_x_d     = core_x;
    core_y_d     = core_y;
    core_z_d     = core_z;
    core_mode_d  = core_mode;
    rsp_valid_d  = rsp_valid;
    rsp_id_d     = rsp_id;
    rsp_err_d    = rsp_err;
    rsp_x_d      = rsp_x;
    rsp_y_d      = rsp_y;
    rsp_z_d      = rsp_z;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;

    case (state)
      IDLE: begin
        if (grant_valid && !rst) begin
          r0_ready     = ~grant;
          r1_ready     = grant;
          core_x_d     = grant ? r1_x : r0_x;
          core_y_d     = grant ? r1_y : r0_y;
          core_z_d     = grant ? r1_z : r0_z;
          core_mode_d  = grant ? r1_mode : r0_mode;
          last_grant_d = grant;
          core_start_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + CW'(1);
        // done takes priority over a coincident timeout
        if (core_done) begin
          rsp_x_d     = core_x_out;
          rsp_y_d     = core_y_out;
          rsp_z_d     = core_z_out;
          rsp_err_d   = 1'b0;
          rsp_id_d    = last_grant;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_x_d     = '0;
          rsp_y_d     = '0;
          rsp_z_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = last_grant;
          rsp_valid_d = 1'b1;
          core_rst_d  = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      core_start <= 1'b0;
      core_rst   <= 1'b1;
      core_x     <= '0;
      core_y     <= '0;
      core_z     <= '0;
      core_mode  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_z      <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
      core_start <= core_start_d;
      core_rst   <= core_rst_d;
      core_x     <= core_x_d;
      core_y     <= core_y_d;
      core_z     <= core_z_d;
      core_mode  <= core_mode_d;
      rsp_valid  <= rsp_valid_d;
      rsp_id     <= rsp_id_d;
      rsp_err    <= rsp_err_d;
      rsp_x      <= rsp_x_d;
      rsp_y      <= rsp_y_d;
      rsp_z      <= rsp_z_d;
    end
  end

endmodule

// File: doc/cordic_linear_arbiter.md
Name: cordic_linear_arbiter

Overview:
Shares one cordic_linear core between two requesters (r0, r1) using round-robin arbitration.
Accepts one operand set per transaction over a valid/ready handshake, registers it, pulses core start, and holds the operands stable until core done.
Returns x/y/z results on a shared response bus tagged with the requester id, under response backpressure.
A watchdog aborts hung operations by resetting the core and returning an error response.

Parameters:
FLOAT_SIZE, 24, fractional bits of fixed-point operands
INT_SIZE, 8, integer bits; data width W = INT_SIZE+FLOAT_SIZE
TIMEOUT, 64, max cycles WAIT may last before abort (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
r0_valid, r1_valid  in  1  request present
r0_ready, r1_ready  out  1  request accepted this cycle
r0_x/r0_y/r0_z, r1_x/r1_y/r1_z  in  W  signed operands
r0_mode, r1_mode  in  1  core mode bit
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester index (0/1)
rsp_x, rsp_y, rsp_z  out  W  signed results (0 on error)
rsp_err  out  1  watchdog abort occurred
core_start  out  1  one-cycle start pulse to core
core_rst  out  1  core reset = rst OR abort pulse
core_x, core_y, core_z  out  W  registered operands to core
core_mode  out  1  registered mode
core_x_out, core_y_out, core_z_out  in  W  core results
core_done  in  1  core completion, sampled only in WAIT

Behaviour:
- Reset (sync, active-high): state=IDLE; last_grant=1 (r0 wins first tie); all outputs 0, except core_rst=1 while rst is high. Reset mid-transaction drops the transaction with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: winner = the only valid requester; if both are valid, winner = !last_grant.
  - rN_ready = (state==IDLE) && winner==N && rN_valid. Combinational; at most one ready is high.
  - On handshake: latch operands/mode into core_* regs and latch id; last_grant<=id; go to ISSUE.
- ISSUE: core_start=1 for exactly this cycle; watchdog counter cleared to 0; go to WAIT.
- WAIT: core_* held stable; counter increments each cycle.
  - If core_done: capture core_*_out into rsp_x/y/z, rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_x/y/z=0, rsp_err=1, core_rst=1 for one cycle, go to RESP.
  - If core_done and the timeout coincide, done wins with no error.
- RESP: rsp_valid=1 with rsp_* stable until rsp_ready. Handshake cycle -> IDLE. No new request is accepted in the handshake cycle; earliest next acceptance is the following cycle.
- core_done outside WAIT is ignored.
- Latency: accept at cycle T, core_start at T+1. If core_done arrives at T+1+L, rsp_valid is first high at T+2+L. Throughput is one transaction in flight.
- Requesters must hold valid and operands until ready. The arbiter never drops a valid request and never grants the same requester twice in a row while the other is waiting.
- Width rules: data passes through unmodified, no arithmetic; the counter is clog2(TIMEOUT) bits.

Decomposition:
- Package cordic_linear_pkg: state enum (IDLE/ISSUE/WAIT/RESP), localparam W, default TIMEOUT.
- Sub-module cordic_rr_arb2: 2-way round-robin grant logic. Inputs valid[1:0] and last_grant; output grant index and grant_valid. Purely combinational.
- The arbiter instantiates cordic_rr_arb2 and one cordic_linear core is connected externally.

Test Plan:
- Single request: r0 sends x=0x0100_0000, y=0, z=0x0080_0000, mode=0; core done after 30 cycles -> r0_ready 1 cycle, core_start 1 cycle later, rsp_valid 32 cycles after accept, rsp_id=0, rsp_x/y/z = core outputs, rsp_err=0.
- Contention: r0 and r1 both valid continuously for 4 transactions -> grant order r0,r1,r0,r1; each ready pulse exactly one cycle; core operands never change between start and done.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, r0_ready/r1_ready stay 0, core_start stays 0; release -> next accept the following cycle.
- Watchdog: core_done never asserted, TIMEOUT=64 -> rsp_valid 65 cycles after start, rsp_err=1, rsp_x/y/z=0, core_rst one-cycle pulse. Also drive core_done exactly on the timeout cycle -> rsp_err=0.
- Reset mid-WAIT: assert rst 5 cycles after start -> next cycle all outputs 0, core_rst=1, no response emitted. After reset, r1 and r0 both valid -> r0 granted first.
- Stray done: pulse core_done in IDLE and RESP -> no state change, response data unchanged.
